stream_demux_1_4: RTL and testbench
===================================

# stream_demux_1_4

Single-input, four-output stream demultiplexer with valid/ready handshakes. Each input beat carries data plus a 2-bit destination. The block routes the beat to one of four registered output channels. This is the routing counterpart of the 4:1 data selector: it distributes one source to four sinks, with backpressure handled independently per channel. Each channel has a one-entry holding register and a saturating delivered-beat counter for debug and visibility.

## Interface
- WIDTH, 4, data width of every beat
- CNT_W, 8, width of each per-channel delivered-beat counter
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  WIDTH  input beat payload
- in_sel  in  2  destination channel 0..3 for the current beat
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts the beat this cycle
- out_data  out  4*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH]
- out_valid  out  4  channel i holds a beat
- out_ready  in  4  sink i accepts this cycle
- out_cnt  out  4*CNT_W  channel i delivered-beat count at bits [i*CNT_W +: CNT_W]
- idle  out  1  all four out_valid bits are 0

## Operation
- Per-channel state:
  - slot_valid[i] drives out_valid[i]
  - slot_data[i] drives out_data slice i
  - cnt[i] drives out_cnt slice i
- in_ready = !rst && (!slot_valid[in_sel] || out_ready[in_sel]).
  - It is combinational from in_sel, out_ready and slot state.
  - It depends only on the addressed channel. A stalled channel never blocks beats to other channels.
- Input transfer: in_valid && in_ready. On the next edge, slot_data[in_sel] <= in_data and slot_valid[in_sel] <= 1.
- Output transfer on channel i: out_valid[i] && out_ready[i].
  - On the next edge, slot_valid[i] <= 0, unless the same channel is refilled in that cycle.
  - cnt[i] increments by 1 and saturates at 2^CNT_W-1. It never wraps.
- Simultaneous drain and refill of one channel: slot_valid stays 1, slot_data takes the new beat, and cnt increments. Full rate is sustained with no bubble.
- Different channels drain and fill independently in the same cycle. Any combination of the four output transfers plus one input transfer is legal.
- While out_valid[i]=1 and out_ready[i]=0, out_data slice i is held stable.
- in_valid=0: no slot is written, regardless of in_sel or in_ready.
- idle = !(|slot_valid). It is combinational.
- No state machine beyond the per-channel valid bit: EMPTY (slot_valid=0) and FULL (slot_valid=1).
  - EMPTY -> FULL on input transfer.
  - FULL -> EMPTY on output transfer without refill.
  - FULL -> FULL on drain with refill, or on stall.

## Timing
- Reset values while rst=1, applied immediately:
  - out_valid=4'b0000, out_data=0, out_cnt=0, idle=1, in_ready=0.
- The first input transfer is possible in the first cycle after rst deasserts.
- Latency: a beat accepted at edge N appears on out_valid and out_data after edge N, so 1 cycle.
- Throughput: 1 beat/cycle total, and 1 beat/cycle into any single channel while its sink holds out_ready=1.
- Reset asserted mid-operation:
  - All held beats are discarded and all counters are cleared asynchronously.
  - Beats presented during reset are not accepted.
- No combinational path from in_valid or in_data to any output. The only combinational paths are out_ready/in_sel -> in_ready and slot_valid -> idle.

## Test plan
- Reset and basic routing:
  - Stimulus: assert rst mid-stream, release, then send in_data=4'hA with in_sel=2, all out_ready=1.
  - Required during reset: in_ready=0, out_valid=0, idle=1.
  - Required after: one cycle later out_valid=4'b0100 and slice 2 = 4'hA. The next cycle out_cnt slice 2 = 1 and idle=1.
- Per-channel backpressure isolation:
  - Stimulus: out_ready=4'b1110, send beat 4'h3 to ch0, then beats 4'h5 and 4'h6 to ch1 on consecutive cycles.
  - Required: ch0 holds 4'h3 with out_valid[0]=1. in_ready=0 whenever in_sel=0. Both ch1 beats are delivered in order and cnt1=2.
- Full-rate drain and refill:
  - Stimulus: out_ready=4'b1111, 16 consecutive beats 0..F all to ch3.
  - Required: in_ready stays 1 throughout, out_valid[3] stays 1 for 16 cycles, data appears in order, cnt3=16.
- Stall-hold stability:
  - Stimulus: ch2 full with 4'hC, out_ready[2]=0 for 5 cycles while new beats target ch2.
  - Required: in_ready=0 for those beats, and slice 2 stays 4'hC.
  - After release: 4'hC is delivered, then the pending beat is accepted the same cycle.
- Counter saturation:
  - Stimulus: CNT_W=4, deliver 20 beats to ch1.
  - Required: out_cnt slice 1 stops at 15 and does not wrap.
- Randomized scoreboard:
  - Stimulus: random in_sel, in_valid and out_ready over 10k cycles.
  - Required: per-channel FIFO-order match, and out_cnt equal to delivered totals (mod saturation).

Source files
------------

// File: rtl/stream_demux_1_4_if.sv
// Handshake bundle for the 1:4 stream demux: one input stream, four output
// channels with their per-channel delivered-beat counters.
interface stream_demux_1_4_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*CNT_W-1:0] out_cnt;
  logic               idle;

  // master = the demux itself
  modport master (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_cnt, idle
  );

  // slave = the environment feeding the source and draining the sinks
  modport slave (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_cnt, idle
  );
endinterface

// File: rtl/stream_demux_1_4.sv
// 1:4 stream demultiplexer: each beat is routed by in_sel into a one-entry
// holding slot per channel, with independent backpressure and a saturating count.
module stream_demux_1_4_lane #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rdy,
  output logic             vld,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t state, state_nxt;
  logic  drain;

  assign vld   = (state == FULL);
  assign drain = vld && rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // A refill in the draining cycle keeps the slot FULL, so there is no bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (wr) state_nxt = FULL;
      FULL:    if (!wr && rdy) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     data <= '0;
    else if (wr) data <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (drain && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end
endmodule

module stream_demux_1_4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  stream_demux_1_4_if.master bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]             wr;
  logic [NUM_LANES-1:0]             vld;
  logic [NUM_LANES-1:0][WIDTH-1:0]  data;
  logic [NUM_LANES-1:0][CNT_W-1:0]  cnt;
  logic                             rdy;
  logic                             acc;

  // Ready looks only at the addressed channel; a stalled sink never blocks the others.
  assign rdy          = !rst && (!vld[bus.in_sel] || bus.out_ready[bus.in_sel]);
  assign acc          = bus.in_valid && rdy;
  assign bus.in_ready = rdy;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wr[i] = acc && (bus.in_sel == 2'(i));

    stream_demux_1_4_lane #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr[i]),
      .wdata (bus.in_data),
      .rdy   (bus.out_ready[i]),
      .vld   (vld[i]),
      .data  (data[i]),
      .cnt   (cnt[i])
    );
  end

  assign bus.out_valid = vld;
  assign bus.out_data  = data;
  assign bus.out_cnt   = cnt;
  assign bus.idle      = ~|vld;
endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: directed scenarios plus random traffic, checked
// against per-channel queues; a CNT_W=4 copy shares the stimulus for saturation.
module tb_stream_demux_1_4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_demux_1_4_if #(.WIDTH(4), .CNT_W(8)) bus ();
  stream_demux_1_4_if #(.WIDTH(4), .CNT_W(4)) bus_s ();

  stream_demux_1_4 #(.WIDTH(4), .CNT_W(8)) dut (
    .clk (clk), .rst (rst), .bus (bus.master)
  );
  stream_demux_1_4 #(.WIDTH(4), .CNT_W(4)) dut_s (
    .clk (clk), .rst (rst), .bus (bus_s.master)
  );

  assign bus_s.in_data   = bus.in_data;
  assign bus_s.in_sel    = bus.in_sel;
  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.out_ready = bus.out_ready;

  int total = 0;
  int bad   = 0;

  // Reference: each channel is a queue of accepted-but-undelivered beats.
  logic [3:0] q [4][$];
  int         dlv [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      dlv[i] = 0;
    end
  endtask

  task automatic check_outputs(input logic exp_rdy);
    logic [3:0]  ev;
    logic [31:0] ec, ecs;
    ev = '0; ec = '0; ecs = '0;
    for (int i = 0; i < 4; i++) begin
      ev[i] = (q[i].size() != 0);
      ec[i*8 +: 8]  = (dlv[i] > 255) ? 8'd255 : 8'(dlv[i]);
      ecs[i*4 +: 4] = (dlv[i] > 15)  ? 4'd15  : 4'(dlv[i]);
    end
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("in_ready_s", 32'(bus_s.in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    for (int i = 0; i < 4; i++)
      if (ev[i]) chk($sformatf("data%0d", i), 32'(bus.out_data[i*4 +: 4]), 32'(q[i][0]));
    chk("out_cnt", bus.out_cnt, ec);
    chk("out_cnt_s", 32'(bus_s.out_cnt), ecs);
    chk("idle", 32'(bus.idle), 32'(ev == 4'b0000));
  endtask

  // One clock: drive inputs just after an edge, check, advance the model, step.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [3:0] d,
                       input logic [3:0] r);
    logic exp_rdy;
    bus.in_valid = v; bus.in_sel = s; bus.in_data = d; bus.out_ready = r;
    #1;
    exp_rdy = (q[s].size() == 0) || r[s];
    check_outputs(exp_rdy);
    for (int i = 0; i < 4; i++)
      if (q[i].size() != 0 && r[i]) begin
        void'(q[i].pop_front());
        dlv[i]++;
      end
    if (v && exp_rdy) q[s].push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rdy"},   32'(bus.in_ready), 32'd0);
    chk({tag, "_vld"},   32'(bus.out_valid), 32'd0);
    chk({tag, "_idle"},  32'(bus.idle), 32'd1);
    chk({tag, "_data"},  32'(bus.out_data), 32'd0);
    chk({tag, "_cnt"},   bus.out_cnt, 32'd0);
    chk({tag, "_cnt_s"}, 32'(bus_s.out_cnt), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = 4'h0; bus.out_ready = 4'h0;
    model_clear();
    @(posedge clk); #1;
    check_reset("rst0");
    rst = 1'b0;
    @(posedge clk); #1;

    // some traffic, then reset mid-stream with a beat presented
    for (int k = 0; k < 20; k++)
      cycle(1'b1, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 4'h9;
    #1;
    check_reset("rst_mid");
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset("rst_hold");
    rst = 1'b0;

    // basic routing
    cycle(1'b1, 2'd2, 4'hA, 4'hF);
    chk("rt_vld", 32'(bus.out_valid), 32'h4);
    chk("rt_data2", 32'(bus.out_data[8 +: 4]), 32'hA);
    cycle(1'b0, 2'd0, 4'h0, 4'hF);
    chk("rt_cnt2", 32'(bus.out_cnt[16 +: 8]), 32'd1);
    chk("rt_idle", 32'(bus.idle), 32'd1);

    // backpressure isolation: ch0 stalled, ch1 keeps flowing
    cycle(1'b1, 2'd0, 4'h3, 4'hE);
    cycle(1'b1, 2'd1, 4'h5, 4'hE);
    cycle(1'b1, 2'd1, 4'h6, 4'hE);
    cycle(1'b1, 2'd0, 4'h7, 4'hE);
    cycle(1'b0, 2'd0, 4'h0, 4'hE);
    chk("bp_vld0", 32'(bus.out_valid[0]), 32'd1);
    chk("bp_data0", 32'(bus.out_data[0 +: 4]), 32'h3);
    chk("bp_cnt1", 32'(bus.out_cnt[8 +: 8]), 32'd2);
    cycle(1'b0, 2'd0, 4'h0, 4'hF);

    // full-rate drain and refill on ch3
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 2'd3, 4'(k), 4'hF);
      chk("fr_vld3", 32'(bus.out_valid[3]), 32'd1);
      chk("fr_data3", 32'(bus.out_data[12 +: 4]), 32'(k));
    end
    cycle(1'b0, 2'd0, 4'h0, 4'hF);
    chk("fr_cnt3", 32'(bus.out_cnt[24 +: 8]), 32'd16);
    chk("fr_cnt3_s", 32'(bus_s.out_cnt[12 +: 4]), 32'd15);

    // stall-hold on ch2
    cycle(1'b1, 2'd2, 4'hC, 4'hF);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 2'd2, 4'(k), 4'b1011);
      chk("st_data2", 32'(bus.out_data[8 +: 4]), 32'hC);
    end
    cycle(1'b1, 2'd2, 4'hD, 4'hF);
    chk("st_next2", 32'(bus.out_data[8 +: 4]), 32'hD);
    chk("st_cnt2", 32'(bus.out_cnt[16 +: 8]), 32'd2);
    cycle(1'b0, 2'd0, 4'h0, 4'hF);

    // saturation: 20 more beats to ch1 (already at 2)
    for (int k = 0; k < 20; k++) cycle(1'b1, 2'd1, 4'($urandom), 4'hF);
    cycle(1'b0, 2'd0, 4'h0, 4'hF);
    chk("sat_cnt1_s", 32'(bus_s.out_cnt[4 +: 4]), 32'd15);
    chk("sat_cnt1", 32'(bus.out_cnt[8 +: 8]), 32'd22);

    // random traffic
    for (int k = 0; k < 10000; k++)
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
            4'($urandom));
    for (int k = 0; k < 2; k++) cycle(1'b0, 2'd0, 4'h0, 4'hF);
    chk("end_idle", 32'(bus.idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
